// File: rtl/bonus_pkg.sv
// Shared types and helpers for the bonus spawner and its LFSR.
// Purely declarative: no latency and no flow control of its own.
package bonus_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, FALLING, COOLDOWN} spawn_state_t;
  typedef enum logic [1:0] {WIDE_PADDLE, SLOW_BALL, EXTRA_LIFE, MULTI_BALL} bonus_type_t;

  localparam int SCREEN_W = 640;
  localparam int BONUS_W  = 32;
  localparam int CNT_W    = 16;

  // Centre under the brick but keep the whole bonus on screen.
  function automatic logic [10:0] clamp_x(input logic [10:0] x, input int off, input int xmax);
    logic [11:0] sum;
    sum = {1'b0, x} + 12'(off);
    return (sum > 12'(xmax)) ? 11'(xmax) : sum[10:0];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), loads SEED on reset.
// Output is the registered value; advances one step per enabled cycle, never stalls.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/bonus_spawner.sv
// Decides on brick hits whether to release a bonus; requests it until bonus_move reports it live.
// All outputs registered (activate one cycle after a winning hit); hits outside IDLE are dropped.
module bonus_spawner
  import bonus_pkg::*;
#(
  parameter int         SPAWN_PROB      = 64,
  parameter int         COOLDOWN_FRAMES = 90,
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  parameter int         X_OFFSET        = 16,
  parameter int         X_MAX           = SCREEN_W - BONUS_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        brickHit,
  input  logic [10:0] brickX,
  input  logic [10:0] brickY,
  input  logic        bonusActive,
  input  logic        bonusCollision,
  input  logic [1:0]  lvl,
  output logic        activate,
  output logic [10:0] topXStart,
  output logic [10:0] topYStart,
  output logic [1:0]  bonusType,
  output logic        caught
);

  spawn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  lvl_q;
  logic        activate_q, activate_d;
  logic        caught_q, caught_d;
  logic        caught_done_q, caught_done_d;
  logic [10:0] topx_q, topx_d;
  logic [10:0] topy_q, topy_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  lfsr;
  logic        spawn_ok;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .lfsr  (lfsr)
  );

  // Nine-bit compare so SPAWN_PROB=256 means "always".
  assign spawn_ok = ({1'b0, lfsr} < 9'(SPAWN_PROB));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    caught_d      = 1'b0;
    caught_done_d = caught_done_q;
    topx_d        = topx_q;
    topy_d        = topy_q;
    type_d        = type_q;
    if (lvl != lvl_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (brickHit && !bonusActive && spawn_ok) begin
            topx_d  = clamp_x(brickX, X_OFFSET, X_MAX);
            topy_d  = brickY;
            type_d  = lfsr[1:0];
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (bonusActive) begin
            state_d       = FALLING;
            caught_done_d = 1'b0;
          end
        end
        FALLING: begin
          // One catch pulse per fall, however long the paddle overlaps.
          if (bonusCollision && bonusActive && !caught_done_q) begin
            caught_d      = 1'b1;
            caught_done_d = 1'b1;
          end
          if (!bonusActive) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = CNT_W'(COOLDOWN_FRAMES);
              state_d = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    activate_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lvl_q         <= 2'd0;
      activate_q    <= 1'b0;
      caught_q      <= 1'b0;
      caught_done_q <= 1'b0;
      topx_q        <= '0;
      topy_q        <= '0;
      type_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lvl_q         <= lvl;
      activate_q    <= activate_d;
      caught_q      <= caught_d;
      caught_done_q <= caught_done_d;
      topx_q        <= topx_d;
      topy_q        <= topy_d;
      type_q        <= type_d;
    end
  end

  assign activate  = activate_q;
  assign topXStart = topx_q;
  assign topYStart = topy_q;
  assign bonusType = type_q;
  assign caught    = caught_q;

endmodule

// File: tb/tb_bonus_spawner.sv
// Three spawner configurations (always / never / 1-in-4 with no cooldown) share one stimulus stream
// and are compared each cycle against a behavioural model, with directed checks on the key scenarios.
module tb_bonus_spawner;

  logic        clk = 1'b0;
  logic        reset, sof, hit, bact, coll;
  logic [10:0] bx, by;
  logic [1:0]  lvl;

  logic        act_o [3];
  logic [10:0] tx_o  [3];
  logic [10:0] ty_o  [3];
  logic [1:0]  typ_o [3];
  logic        cau_o [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bonus_spawner #(.SPAWN_PROB(256), .COOLDOWN_FRAMES(3)) u_always (
    .clk(clk), .reset(reset), .startOfFrame(sof), .brickHit(hit), .brickX(bx), .brickY(by),
    .bonusActive(bact), .bonusCollision(coll), .lvl(lvl),
    .activate(act_o[0]), .topXStart(tx_o[0]), .topYStart(ty_o[0]), .bonusType(typ_o[0]), .caught(cau_o[0]));

  bonus_spawner #(.SPAWN_PROB(0)) u_never (
    .clk(clk), .reset(reset), .startOfFrame(sof), .brickHit(hit), .brickX(bx), .brickY(by),
    .bonusActive(bact), .bonusCollision(coll), .lvl(lvl),
    .activate(act_o[1]), .topXStart(tx_o[1]), .topYStart(ty_o[1]), .bonusType(typ_o[1]), .caught(cau_o[1]));

  bonus_spawner #(.SPAWN_PROB(64), .COOLDOWN_FRAMES(0)) u_rand (
    .clk(clk), .reset(reset), .startOfFrame(sof), .brickHit(hit), .brickX(bx), .brickY(by),
    .bonusActive(bact), .bonusCollision(coll), .lvl(lvl),
    .activate(act_o[2]), .topXStart(tx_o[2]), .topYStart(ty_o[2]), .bonusType(typ_o[2]), .caught(cau_o[2]));

  // Reference model: mode 0 waiting, 1 requesting, 2 bonus on screen, 3 frame cooldown.
  int m_prob [3] = '{256, 0, 64};
  int m_cdn  [3] = '{3, 90, 0};
  int seq [255];
  int m_mode [3], m_cnt [3], m_n [3], m_tx [3], m_ty [3], m_typ [3];
  bit m_act [3], m_cau [3], m_cdone [3];
  logic [1:0] m_lvl [3];
  logic [7:0] lf_gen;
  int ncau;

  task automatic model_step(input int k);
    int cur;
    bit cau;
    cau = 1'b0;
    if (reset) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_n[k] = 0; m_lvl[k] = 2'd0;
      m_tx[k] = 0; m_ty[k] = 0; m_typ[k] = 0; m_cdone[k] = 1'b0;
    end else begin
      cur = seq[m_n[k] % 255];
      m_n[k]++;
      if (lvl != m_lvl[k]) begin
        m_mode[k] = 0;
        m_cnt[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (hit && !bact && cur < m_prob[k]) begin
          m_tx[k]   = (int'(bx) + 16 > 608) ? 608 : int'(bx) + 16;
          m_ty[k]   = int'(by);
          m_typ[k]  = cur % 4;
          m_mode[k] = 1;
        end
      end else if (m_mode[k] == 1) begin
        if (bact) begin m_mode[k] = 2; m_cdone[k] = 1'b0; end
      end else if (m_mode[k] == 2) begin
        if (coll && bact && !m_cdone[k]) begin cau = 1'b1; m_cdone[k] = 1'b1; end
        if (!bact) begin
          m_cnt[k]  = m_cdn[k];
          m_mode[k] = (m_cdn[k] == 0) ? 0 : 3;
        end
      end else if (sof) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_mode[k] = 0;
      end
      m_lvl[k] = lvl;
    end
    m_cau[k] = cau;
    m_act[k] = (m_mode[k] == 1);
  endtask

  task automatic chk(input string tag, input int k, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model_step(k);
    for (int k = 0; k < 3; k++) begin
      chk("activate",  k, 12'(act_o[k]), 12'(m_act[k]));
      chk("topXStart", k, 12'(tx_o[k]),  12'(m_tx[k]));
      chk("topYStart", k, 12'(ty_o[k]),  12'(m_ty[k]));
      chk("bonusType", k, 12'(typ_o[k]), 12'(m_typ[k]));
      chk("caught",    k, 12'(cau_o[k]), 12'(m_cau[k]));
    end
  endtask

  initial begin
    lf_gen = 8'hA5;
    for (int i = 0; i < 255; i++) begin
      seq[i] = int'(lf_gen);
      lf_gen = {lf_gen[6:0], lf_gen[7] ^ lf_gen[5] ^ lf_gen[4] ^ lf_gen[3]};
    end

    reset = 1'b1; sof = 1'b0; hit = 1'b0; bx = '0; by = '0; bact = 1'b0; coll = 1'b0; lvl = 2'd1;
    tick(); tick();
    chk("rst_activate", 0, 12'(act_o[0]), 12'd0);
    chk("rst_topX",     0, 12'(tx_o[0]),  12'd0);
    reset = 1'b0;
    tick(); tick();

    // Always-spawn: hit at (100,200) arms next cycle with centred X.
    hit = 1'b1; bx = 11'd100; by = 11'd200;
    tick();
    hit = 1'b0;
    chk("t1_activate", 0, 12'(act_o[0]), 12'd1);
    chk("t1_topX",     0, 12'(tx_o[0]),  12'd116);
    chk("t1_topY",     0, 12'(ty_o[0]),  12'd200);
    chk("t2_never",    1, 12'(act_o[1]), 12'd0);
    tick();
    chk("t1_hold",     0, 12'(act_o[0]), 12'd1);
    bact = 1'b1;
    tick();
    chk("t1_release",  0, 12'(act_o[0]), 12'd0);

    // Collision held three cycles gives a single catch pulse.
    ncau = 0;
    coll = 1'b1;
    repeat (3) begin tick(); ncau += int'(cau_o[0]); end
    coll = 1'b0;
    tick(); ncau += int'(cau_o[0]);
    chk("t4_caught_count", 0, 12'(ncau), 12'd1);

    // Cooldown of three frames blocks spawns until the third frame pulse.
    bact = 1'b0;
    tick();
    sof = 1'b1; tick(); sof = 1'b0; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    hit = 1'b1; bx = 11'd300; by = 11'd50;
    tick();
    hit = 1'b0;
    chk("t4_blocked", 0, 12'(act_o[0]), 12'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    hit = 1'b1; bx = 11'd620; by = 11'd40;
    tick();
    hit = 1'b0;
    chk("t4_respawn", 0, 12'(act_o[0]), 12'd1);
    chk("t3_clamp",   0, 12'(tx_o[0]),  12'd608);

    // Level change while armed cancels the request with no cooldown.
    lvl = 2'd2;
    tick();
    chk("t5_cancel", 0, 12'(act_o[0]), 12'd0);
    tick();
    hit = 1'b1; bx = 11'd10; by = 11'd20;
    tick();
    hit = 1'b0;
    chk("t5_spawn", 0, 12'(act_o[0]), 12'd1);
    chk("t5_topX",  0, 12'(tx_o[0]),  12'd26);

    // Reset in the middle of a fall.
    bact = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; bact = 1'b0;
    chk("t6_activate", 0, 12'(act_o[0]), 12'd0);
    chk("t6_topX",     0, 12'(tx_o[0]),  12'd0);
    chk("t6_topY",     0, 12'(ty_o[0]),  12'd0);
    chk("t6_type",     0, 12'(typ_o[0]), 12'd0);
    tick();

    // After reset the draw sequence restarts; the model checks each decision.
    for (int i = 0; i < 24; i++) begin
      hit = 1'b1; bx = 11'(i * 37); by = 11'(i);
      tick();
    end
    hit = 1'b0;

    for (int i = 0; i < 2500; i++) begin
      hit  = ($urandom_range(99) < 30);
      sof  = ($urandom_range(99) < 15);
      bx   = 11'($urandom_range(2047));
      by   = 11'($urandom_range(2047));
      coll = ($urandom_range(99) < 25);
      if ($urandom_range(99) < 12) bact = ~bact;
      if ($urandom_range(999) < 5) lvl = 2'($urandom_range(3));
      reset = ($urandom_range(999) < 2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
